relu_maxpool: RTL and testbench

//   Streaming ReLU + 2x2/stride-2 max-pool stage that sits directly downstream of conv_layer.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool_line_buffer.sv | 29 ++
 rtl/relu_maxpool.sv | 152 +++++++++++++++
 tb/tb_relu_maxpool.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: sample width/plane size defaults, the pool FSM
// state encoding and a signed max helper used by the pooling stage.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int IMG_SIZE_DEF   = 30;

    typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pool_state_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width row store for the 2x2 pool: holds the horizontal max of each
// column pair from the even row until the odd row arrives.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH      = 15,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]                rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    // No reset: every entry is rewritten on the even row before it is read.
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU + 2x2/stride-2 max-pool. Optional ReLU is enabled by
// defining POOL_RELU_EN; without it the stage is a pure signed max-pool.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for enable; in_ready low
//   RUN   | accepting conv samples, counting x/y/f, loading pooled outputs
//   DRAIN | all inputs taken; waiting for the final output handshake
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int IMG_SIZE   = IMG_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_F      = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         done
);

    localparam int POOL_OUT = IMG_SIZE / 2;
    localparam int XW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int FW       = (NUM_F > 1) ? $clog2(NUM_F) : 1;
    localparam int AW       = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_SIZE - 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_F - 1);

    generate
        if ((IMG_SIZE % 2) != 0) begin : g_size_chk
            $error("relu_maxpool: IMG_SIZE must be even");
        end
        if (DATA_WIDTH != $bits(sample_t)) begin : g_width_chk
            $error("relu_maxpool: DATA_WIDTH must match cnn_pkg sample_t");
        end
    endgenerate

    pool_state_t   state;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [FW-1:0] f;
    sample_t       h;

    sample_t       s_eff;
    sample_t       h_new;
    sample_t       lb_rd;
    logic          accept;
    logic          lb_wr;
    logic          load;
    logic [AW-1:0] col;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef POOL_RELU_EN
    assign s_eff = (in_data < 0) ? '0 : in_data;
`else
    assign s_eff = in_data;
`endif

    // Horizontal pair max: even column seeds h, odd column closes the pair.
    assign h_new = x[0] ? smax(h, s_eff) : s_eff;
    assign col   = AW'(x >> 1);
    assign lb_wr = accept && !y[0] && x[0];
    assign load  = accept && y[0] && x[0];

    pool_line_buffer #(
        .DEPTH      (POOL_OUT),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (col),
        .wr_data (h_new),
        .rd_addr (col),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            f         <= '0;
            h         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // A load in the same cycle as a drain handshake overwrites the slot.
            if (load) begin
                out_data  <= smax(lb_rd, h_new);
                out_valid <= 1'b1;
                out_last  <= (x == X_LAST) && (y == X_LAST);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                h <= h_new;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == X_LAST) begin
                                y <= '0;
                                if (f == F_LAST) begin
                                    f     <= '0;
                                    state <= DRAIN;
                                end else begin
                                    f <= f + 1'b1;
                                end
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool with 4x4 planes: one single-plane instance
// for the vector table and corner sequences, one two-plane instance.
module tb_relu_maxpool;

`ifdef POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic en1, en2, iv1, iv2, or1, or2;
    logic signed [15:0] din;
    logic ir1, ir2, ov1, ov2, ol1, ol2, dn1, dn2;
    logic signed [15:0] od1, od2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int q1_data[$];
    bit q1_last[$];
    int q2_data[$];
    bit q2_last[$];
    int done1 = 0, done2 = 0;
    int hs_cyc1 = 0, done_cyc1 = 0;
    int stim[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_maxpool #(.IMG_SIZE(4), .DATA_WIDTH(16), .NUM_F(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(en1), .in_data(din), .in_valid(iv1),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(or1),
        .out_last(ol1), .done(dn1)
    );

    relu_maxpool #(.IMG_SIZE(4), .DATA_WIDTH(16), .NUM_F(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .in_data(din), .in_valid(iv2),
        .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(or2),
        .out_last(ol2), .done(dn2)
    );

    always @(negedge clk) begin
        if (ov1 && or1) begin
            q1_data.push_back(int'(od1));
            q1_last.push_back(ol1);
            hs_cyc1 = cyc;
        end
        if (dn1) begin
            done1++;
            done_cyc1 = cyc;
        end
        if (ov2 && or2) begin
            q2_data.push_back(int'(od2));
            q2_last.push_back(ol2);
        end
        if (dn2) done2++;
    end

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int r(input int v);
        return (RELU && v < 0) ? 0 : v;
    endfunction

    task automatic pulse_enable(input int d);
        @(posedge clk); #1;
        if (d == 0) en1 = 1'b1; else en2 = 1'b1;
        @(posedge clk); #1;
        if (d == 0) en1 = 1'b0; else en2 = 1'b0;
    endtask

    task automatic send(input int d, input int n, input bit bubbles);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            din = 16'(stim[i]);
            if (d == 0) iv1 = 1'b1; else iv2 = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = (d == 0) ? ir1 : ir2;
                @(posedge clk); #1;
                t++;
            end
            iv1 = 1'b0;
            iv2 = 1'b0;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout sample %0d got no accept expected accept", i);
                return;
            end
        end
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (((d == 0) ? done1 : done2) == 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run1(input bit bubbles);
        q1_data.delete();
        q1_last.delete();
        done1 = 0;
        fork
            pulse_enable(0);
            send(0, 16, bubbles);
        join
        wait_done(0);
    endtask

    task automatic check_frame1(input string nm, input int exp[4]);
        check({nm, "_count"}, q1_data.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < q1_data.size()) begin
                check($sformatf("%s_data%0d", nm, k), q1_data[k], exp[k]);
                check($sformatf("%s_last%0d", nm, k), q1_last[k], (k == 3));
            end
        end
        check({nm, "_done_count"}, done1, 1);
        check({nm, "_done_delay"}, done_cyc1 - hs_cyc1, 1);
    endtask

    typedef struct {
        string name;
        int    img[16];
        int    exp[4];
    } vec_t;

    vec_t tbl[4];
    int ramp_exp[4];
    int held;

    initial begin
        tbl[0].name = "ramp";
        tbl[0].img  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        tbl[0].exp  = '{5, 7, 13, 15};
        tbl[1].name = "neg_block";
        tbl[1].img  = '{-3, -1, 10, 20, -7, -2, 30, 5, -5, -6, -7, -8, -9, -10, -11, -4};
        tbl[1].exp  = '{r(-1), 30, r(-5), r(-4)};
        tbl[2].name = "extremes";
        tbl[2].img  = '{32767, -32768, 0, 1, -32768, -32768, 2, -1, 0, 0, -1, -1, 0, 0, -1, -1};
        tbl[2].exp  = '{32767, 2, 0, r(-1)};
        tbl[3].name = "max_pos";
        tbl[3].img  = '{9, 1, 1, 1, 1, 1, 1, 9, 1, 8, 7, 1, 1, 1, 1, 1};
        tbl[3].exp  = '{9, 9, 8, 7};
        ramp_exp = tbl[0].exp;

        reset_n = 1'b0;
        en1 = 1'b0; en2 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        or1 = 1'b1; or2 = 1'b1; din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", ov1, 0);
        check("rst_out_data", od1, 0);
        check("rst_out_last", ol1, 0);
        check("rst_done", dn1, 0);
        check("rst_in_ready", ir1, 0);
        check("rst_out_valid2", ov2, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_in_ready", ir1, 0);

        for (int v = 0; v < 4; v++) begin
            stim.delete();
            for (int i = 0; i < 16; i++) stim.push_back(tbl[v].img[i]);
            run1(1'b0);
            check_frame1(tbl[v].name, tbl[v].exp);
        end

        // Backpressure: stall the first output for 5 cycles.
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(i);
        fork
            run1(1'b0);
            begin
                int t = 0;
                while (!ov1 && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                or1 = 1'b0;
                held = int'(od1);
                check("bp_first_value", held, 5);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", ir1, 0);
                    check("bp_out_valid", ov1, 1);
                    check("bp_out_stable", od1, held);
                end
                @(posedge clk); #1;
                or1 = 1'b1;
            end
        join
        check_frame1("backpressure", ramp_exp);

        // Two planes on dut2.
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(100);
        for (int i = 0; i < 16; i++) stim.push_back(-32768);
        q2_data.delete();
        q2_last.delete();
        done2 = 0;
        fork
            pulse_enable(1);
            send(1, 32, 1'b0);
        join
        wait_done(1);
        check("nf2_count", q2_data.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < q2_data.size()) begin
                check($sformatf("nf2_data%0d", k), q2_data[k], (k < 4) ? 100 : r(-32768));
                check($sformatf("nf2_last%0d", k), q2_last[k], (k == 3 || k == 7));
            end
        end
        check("nf2_done_count", done2, 1);

        // Abort mid-frame with reset, then a clean frame.
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(i);
        done1 = 0;
        fork
            pulse_enable(0);
            send(0, 6, 1'b0);
        join
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_out_valid", ov1, 0);
        check("abort_in_ready", ir1, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done1, 0);
        run1(1'b0);
        check_frame1("after_abort", ramp_exp);

        // Enable pulses during RUN plus input bubbles.
        fork
            run1(1'b1);
            begin
                repeat (6) @(posedge clk);
                #1; en1 = 1'b1;
                @(posedge clk); #1; en1 = 1'b0;
                repeat (5) @(posedge clk);
                #1; en1 = 1'b1;
                @(posedge clk); #1; en1 = 1'b0;
            end
        join
        check_frame1("enable_bubbles", ramp_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
